multiword_add_sequencer: RTL and testbench

//   Multi-precision add/subtract controller that time-shares one N-bit

---
 rtl/multiword_add_sequencer.sv | 133 +++++++++++++
 tb/tb_multiword_add_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_sequencer.sv
// Multi-precision add/subtract: one N-bit ripple-carry adder is reused over
// WORDS operand words, least-significant word first, one word per clock.

module ripple_carry_adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] c;

    assign c[0] = cin;
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[N];
endmodule

module multiword_add_sequencer #(
    parameter int N     = 16,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sub,
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   b,
    output logic                 busy,
    output logic                 done,
    output logic [N*WORDS-1:0]   sum,
    output logic                 cout,
    output logic                 overflow
);
    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, next_state;
    logic [IW-1:0]  idx;
    logic           carry;
    logic [W-1:0]   a_reg, b_reg;
    logic           sub_reg;

    logic [N-1:0]   a_word, b_sel, b_word, add_sum;
    logic           add_cout;
    logic           last, accept;

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign last   = (idx == IW'(WORDS - 1));
    // The done cycle may also accept the next request, so operations chain
    // with a period of WORDS+1 cycles while start is held.
    assign accept = start && ((state == IDLE) || (state == DONE));

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves a value unassigned and no latch is inferred.
        a_word = '0;
        b_sel  = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx == IW'(w)) begin
                a_word = a_reg[w*N +: N];
                b_sel  = b_reg[w*N +: N];
            end
        end
    end

    assign b_word = b_sel ^ {N{sub_reg}};

    ripple_carry_adder #(.N(N)) u_adder (
        .a    (a_word),
        .b    (b_word),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last)  next_state = DONE;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            sub_reg  <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_reg   <= a;
            b_reg   <= b;
            sub_reg <= sub;
            idx     <= '0;
            carry   <= sub;
        end else if (state == RUN) begin
            for (int w = 0; w < WORDS; w++) begin
                if (idx == IW'(w)) sum[w*N +: N] <= add_sum;
            end
            carry <= add_cout;
            idx   <= idx + 1'b1;
            if (last) begin
                cout     <= add_cout;
                // Carry into the MSB recovered from the MSB's own sum bit.
                overflow <= (a_word[N-1] ^ b_word[N-1] ^ add_sum[N-1]) ^ add_cout;
            end
        end
    end
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer: three parameterisations,
// directed corner cases on the 16x4 instance and random regression on all.

module tb_multiword_add_sequencer;
    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   passed = 0;
    int   total  = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    logic        start0 = 0, sub0 = 0, busy0, done0, cout0, ovf0;
    logic [63:0] a0 = '0, b0 = '0, sum0;
    logic        start1 = 0, sub1 = 0, busy1, done1, cout1, ovf1;
    logic [7:0]  a1 = '0, b1 = '0, sum1;
    logic        start2 = 0, sub2 = 0, busy2, done2, cout2, ovf2;
    logic [11:0] a2 = '0, b2 = '0, sum2;

    multiword_add_sequencer #(.N(16), .WORDS(4)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .sub(sub0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .overflow(ovf0));
    multiword_add_sequencer #(.N(8), .WORDS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1));
    multiword_add_sequencer #(.N(4), .WORDS(3)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .overflow(ovf2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int width_of(input int d);
        return (d == 0) ? 64 : (d == 1) ? 8 : 12;
    endfunction

    function automatic int words_of(input int d);
        return (d == 0) ? 4 : (d == 1) ? 1 : 3;
    endfunction

    // Reference: W-bit two's-complement add/sub with carry and signed overflow.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic s, input int w);
        exp_t        r;
        logic [64:0] mask, aa, bb, full;
        mask   = (65'd1 << w) - 65'd1;
        aa     = {1'b0, a} & mask;
        bb     = s ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
        full   = aa + bb + {64'd0, s};
        r.sum  = full[63:0] & mask[63:0];
        r.cout = full[w];
        r.ovf  = (aa[w-1] == bb[w-1]) && (r.sum[w-1] != aa[w-1]);
        return r;
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = '1;
            1:       v = 64'd1 << (w - 1);
            2:       v = ~(64'd1 << (w - 1));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic drive(input int d, input logic st, input logic [63:0] av,
                         input logic [63:0] bv, input logic s);
        case (d)
            0: begin start0 = st; a0 = av;       b0 = bv;       sub0 = s; end
            1: begin start1 = st; a1 = av[7:0];  b1 = bv[7:0];  sub1 = s; end
            default: begin start2 = st; a2 = av[11:0]; b2 = bv[11:0]; sub2 = s; end
        endcase
    endtask

    task automatic push(input int d, input exp_t e);
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic logic done_of(input int d);
        return (d == 0) ? done0 : (d == 1) ? done1 : done2;
    endfunction

    function automatic logic busy_of(input int d);
        return (d == 0) ? busy0 : (d == 1) ? busy1 : busy2;
    endfunction

    task automatic score(input int d);
        exp_t        e;
        logic [63:0] s;
        logic        c, o;
        case (d)
            0: begin s = sum0;          c = cout0; o = ovf0; end
            1: begin s = 64'(sum1);     c = cout1; o = ovf1; end
            default: begin s = 64'(sum2); c = cout2; o = ovf2; end
        endcase
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0) ||
            (d == 2 && q2.size() == 0)) begin
            check($sformatf("d%0d_unexpected_done", d), 64'd1, 64'd0);
        end else begin
            e = (d == 0) ? q0.pop_front() : (d == 1) ? q1.pop_front() : q2.pop_front();
            check($sformatf("d%0d_sum", d),  s, e.sum);
            check($sformatf("d%0d_cout", d), 64'(c), 64'(e.cout));
            check($sformatf("d%0d_ovf", d),  64'(o), 64'(e.ovf));
        end
    endtask

    always @(negedge clk) if (done0) score(0);
    always @(negedge clk) if (done1) score(1);
    always @(negedge clk) if (done2) score(2);

    // Called just after a negedge with the DUT idle or in its done cycle;
    // returns at the negedge where done is seen.
    task automatic do_op(input int d, input logic [63:0] av, input logic [63:0] bv,
                         input logic s);
        int   st_cyc;
        logic got;
        drive(d, 1'b1, av, bv, s);
        push(d, model(av, bv, s, width_of(d)));
        st_cyc = cyc + 1;
        @(negedge clk);
        drive(d, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
        check($sformatf("d%0d_busy", d), 64'(busy_of(d)), 64'd1);
        got = 1'b0;
        for (int k = 0; k < words_of(d) + 3; k++) begin
            if (done_of(d)) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check($sformatf("d%0d_latency", d), got ? 64'(cyc - st_cyc) : '1,
              64'(words_of(d)));
    endtask

    task automatic directed(input string tag, input logic [63:0] av, input logic [63:0] bv,
                            input logic s, input logic [63:0] es, input logic ec,
                            input logic eo);
        do_op(0, av, bv, s);
        check({tag, "_sum"},  sum0, es);
        check({tag, "_cout"}, 64'(cout0), 64'(ec));
        check({tag, "_ovf"},  64'(ovf0), 64'(eo));
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_done", 64'(done0), 64'd0);
        check("rst_sum",  sum0, 64'd0);
        check("rst_cout", 64'(cout0), 64'd0);
        check("rst_ovf",  64'(ovf0), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        directed("word_carry", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0,
                 64'h0000_0000_0001_0000, 1'b0, 1'b0);
        directed("add_wrap", '1, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0);
        directed("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        directed("sub_borrow", 64'd0, 64'd1, 1'b1, '1, 1'b0, 1'b0);
        directed("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b1,
                 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

        // start held high with operands changing every cycle
        for (int n = 0; n <= 15; n++) begin
            logic [63:0] av, bv;
            logic        s;
            av = pick(64);
            bv = pick(64);
            s  = 1'($urandom);
            if (n > 0) check("hold_done", 64'(done0), 64'(n % 5 == 0));
            if (n < 15) begin
                drive(0, 1'b1, av, bv, s);
                if (n % 5 == 0) push(0, model(av, bv, s, 64));
                @(negedge clk);
            end else begin
                drive(0, 1'b0, av, bv, s);
            end
        end

        // abort after two RUN edges
        drive(0, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, '0, '0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy0), 64'd0);
        check("abort_done", 64'(done0), 64'd0);
        check("abort_sum",  sum0, 64'd0);
        check("abort_cout", 64'(cout0), 64'd0);
        check("abort_ovf",  64'(ovf0), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        directed("post_abort", 64'h0000_0000_0000_FFFF, 64'd0, 1'b0,
                 64'h0000_0000_0000_FFFF, 1'b0, 1'b0);

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 1000; i++) begin
                do_op(d, pick(width_of(d)), pick(width_of(d)), 1'($urandom));
            end
        end
        @(negedge clk);
        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);
        check("q2_drained", 64'(q2.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
